commit_trace_buffer: RTL and testbench

//  Core-side producer of the simulator debug/difftest interface: captures retired instructions

---
 rtl/npc_trace_pkg.sv | 22 ++
 rtl/trace_fifo.sv | 53 +++++
 rtl/commit_trace_buffer.sv | 114 +++++++++++
 tb/tb_commit_trace_buffer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/npc_trace_pkg.sv
// Shared types for the commit trace path: queued entry layout and drain FSM states.
package npc_trace_pkg;

  localparam int XLEN_DEF  = 64;
  localparam int SEQ_W_DEF = 32;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } trace_state_e;

  typedef struct packed {
    logic [XLEN_DEF-1:0]  pc;
    logic [31:0]          inst;
    logic                 rd_wen;
    logic [4:0]           rd;
    logic [XLEN_DEF-1:0]  rd_data;
    logic [SEQ_W_DEF-1:0] seq;
  } commit_entry_t;

endpackage

// File: rtl/trace_fifo.sv
// Sync FIFO of commit entries; push-to-head latency 1 cycle, head read combinationally.
// Backpressure: full/empty from registered count; push when full and pop when empty are dropped.
module trace_fifo
  import npc_trace_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  commit_entry_t push_entry,
  input  logic          pop,
  output commit_entry_t head,
  output logic          full,
  output logic          empty,
  output logic [PTR_W:0] count
);

  commit_entry_t    mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only observable behind count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/commit_trace_buffer.sv
// Queues retired instructions for the trace reader and keeps a shadow GPR file in drain order;
// trace_valid 1 cycle after push; commit_ready drops when full or once ebreak is accepted.
module commit_trace_buffer
  import npc_trace_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int XLEN  = XLEN_DEF,
  parameter int SEQ_W = SEQ_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 commit_valid,
  output logic                 commit_ready,
  input  logic [XLEN-1:0]      commit_pc,
  input  logic [31:0]          commit_inst,
  input  logic                 commit_rd_wen,
  input  logic [4:0]           commit_rd,
  input  logic [XLEN-1:0]      commit_rd_data,
  input  logic                 commit_is_break,
  output logic                 trace_valid,
  input  logic                 trace_ready,
  output logic [XLEN-1:0]      trace_pc,
  output logic [31:0]          trace_inst,
  output logic                 trace_rd_wen,
  output logic [4:0]           trace_rd,
  output logic [XLEN-1:0]      trace_rd_data,
  output logic [SEQ_W-1:0]     trace_seq,
  output logic [32*XLEN-1:0]   shadow_gpr,
  output logic                 halt_valid,
  output logic [XLEN-1:0]      halt_code
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  trace_state_e          state;
  logic [SEQ_W-1:0]      seq_cnt;
  logic [31:0][XLEN-1:0] gpr;
  commit_entry_t         push_entry;
  commit_entry_t         head;
  logic                  full;
  logic                  empty;
  logic [CNT_W-1:0]      count;
  logic                  push;
  logic                  pop;

  assign commit_ready = (state == RUN) & ~full;
  assign push         = commit_valid & commit_ready;
  assign trace_valid  = ~empty;
  assign pop          = trace_valid & trace_ready;

  always_comb begin
    push_entry         = '0;
    push_entry.pc      = XLEN_DEF'(commit_pc);
    push_entry.inst    = commit_inst;
    push_entry.rd_wen  = commit_rd_wen;
    push_entry.rd      = commit_rd;
    push_entry.rd_data = XLEN_DEF'(commit_rd_data);
    push_entry.seq     = SEQ_W_DEF'(seq_cnt);
  end

  trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .full       (full),
    .empty      (empty),
    .count      (count)
  );

  assign trace_pc      = head.pc[XLEN-1:0];
  assign trace_inst    = head.inst;
  assign trace_rd_wen  = head.rd_wen;
  assign trace_rd      = head.rd;
  assign trace_rd_data = head.rd_data[XLEN-1:0];
  assign trace_seq     = head.seq[SEQ_W-1:0];
  assign shadow_gpr    = gpr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq_cnt <= '0;
      gpr     <= '0;
    end else begin
      if (push) seq_cnt <= seq_cnt + SEQ_W'(1);
      // x0 is never written, so it stays at its reset value of zero.
      if (pop && head.rd_wen && head.rd != 5'd0) gpr[head.rd] <= head.rd_data[XLEN-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      halt_valid <= 1'b0;
      halt_code  <= '0;
    end else begin
      case (state)
        RUN:    if (push && commit_is_break) state <= DRAIN;
        DRAIN: begin
          // Empty here means the last pop already landed in the shadow file.
          if (count == '0) begin
            state      <= HALTED;
            halt_valid <= 1'b1;
            halt_code  <= gpr[10];
          end
        end
        HALTED: state <= HALTED;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Randomized bench with a queue-based reference model and a negedge scoreboard.
module tb_commit_trace_buffer;

  localparam int DEPTH = 8;
  localparam int XLEN  = 64;
  localparam int SEQ_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              commit_valid;
  logic              commit_ready;
  logic [XLEN-1:0]   commit_pc;
  logic [31:0]       commit_inst;
  logic              commit_rd_wen;
  logic [4:0]        commit_rd;
  logic [XLEN-1:0]   commit_rd_data;
  logic              commit_is_break;
  logic              trace_valid;
  logic              trace_ready;
  logic [XLEN-1:0]   trace_pc;
  logic [31:0]       trace_inst;
  logic              trace_rd_wen;
  logic [4:0]        trace_rd;
  logic [XLEN-1:0]   trace_rd_data;
  logic [SEQ_W-1:0]  trace_seq;
  logic [32*XLEN-1:0] shadow_gpr;
  logic              halt_valid;
  logic [XLEN-1:0]   halt_code;

  commit_trace_buffer #(.DEPTH(DEPTH), .XLEN(XLEN), .SEQ_W(SEQ_W)) dut (
    .clk(clk), .rst(rst),
    .commit_valid(commit_valid), .commit_ready(commit_ready),
    .commit_pc(commit_pc), .commit_inst(commit_inst),
    .commit_rd_wen(commit_rd_wen), .commit_rd(commit_rd),
    .commit_rd_data(commit_rd_data), .commit_is_break(commit_is_break),
    .trace_valid(trace_valid), .trace_ready(trace_ready),
    .trace_pc(trace_pc), .trace_inst(trace_inst),
    .trace_rd_wen(trace_rd_wen), .trace_rd(trace_rd),
    .trace_rd_data(trace_rd_data), .trace_seq(trace_seq),
    .shadow_gpr(shadow_gpr), .halt_valid(halt_valid), .halt_code(halt_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        wen;
    logic [4:0]  rd;
    logic [63:0] data;
    int          seq;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  logic [63:0] mgpr [32];
  int          mstate;   // 0 running, 1 draining, 2 halted
  int          mseq;
  logic [63:0] mcode;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic chk_shadow();
    logic [32*XLEN-1:0] flat;
    for (int i = 0; i < 32; i++) flat[i*XLEN +: XLEN] = mgpr[i];
    checks++;
    if (shadow_gpr !== flat) begin
      errors++;
      for (int i = 0; i < 32; i++)
        if (shadow_gpr[i*XLEN +: XLEN] !== flat[i*XLEN +: XLEN]) begin
          $display("FAIL shadow_x%0d: got %h expected %h at %0t",
                   i, shadow_gpr[i*XLEN +: XLEN], flat[i*XLEN +: XLEN], $time);
          break;
        end
    end
  endtask

  // Scoreboard: compare against model state, then advance model across the coming edge.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      for (int i = 0; i < 32; i++) mgpr[i] = '0;
      mstate = 0;
      mseq   = 0;
      mcode  = '0;
      chk("rst_commit_ready", 64'(commit_ready), 64'd1);
      chk("rst_trace_valid", 64'(trace_valid), 64'd0);
      chk("rst_halt_valid", 64'(halt_valid), 64'd0);
      chk("rst_halt_code", halt_code, 64'd0);
      chk_shadow();
    end else begin
      bit push_ok, pop_ok, was_empty;
      chk("commit_ready", 64'(commit_ready), 64'(mstate == 0 && exp_q.size() < DEPTH));
      chk("trace_valid", 64'(trace_valid), 64'(exp_q.size() > 0));
      if (exp_q.size() > 0) begin
        chk("trace_pc", trace_pc, exp_q[0].pc);
        chk("trace_inst", 64'(trace_inst), 64'(exp_q[0].inst));
        chk("trace_rd_wen", 64'(trace_rd_wen), 64'(exp_q[0].wen));
        chk("trace_rd", 64'(trace_rd), 64'(exp_q[0].rd));
        chk("trace_rd_data", trace_rd_data, exp_q[0].data);
        chk("trace_seq", 64'(trace_seq), 64'(exp_q[0].seq));
      end
      chk("halt_valid", 64'(halt_valid), 64'(mstate == 2));
      chk("halt_code", halt_code, mcode);
      chk_shadow();

      was_empty = (exp_q.size() == 0);
      push_ok   = commit_valid && mstate == 0 && exp_q.size() < DEPTH;
      pop_ok    = trace_ready && exp_q.size() > 0;
      if (pop_ok) begin
        e = exp_q.pop_front();
        if (e.wen && e.rd != 5'd0) mgpr[e.rd] = e.data;
      end
      if (mstate == 1 && was_empty) begin
        mstate = 2;
        mcode  = mgpr[10];
      end
      if (push_ok) begin
        e.pc = commit_pc; e.inst = commit_inst; e.wen = commit_rd_wen;
        e.rd = commit_rd; e.data = commit_rd_data; e.seq = mseq;
        exp_q.push_back(e);
        mseq = (mseq + 1) % (1 << SEQ_W);
        if (commit_is_break) mstate = 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_commit(input logic [63:0] pc, input logic [31:0] inst, input logic wen,
                            input logic [4:0] rd, input logic [63:0] d, input logic brk);
    commit_valid = 1'b1; commit_pc = pc; commit_inst = inst;
    commit_rd_wen = wen; commit_rd = rd; commit_rd_data = d; commit_is_break = brk;
  endtask

  // Hold the commit until it is taken; expiry of the bound is a failure.
  task automatic push_one(input logic [63:0] pc, input logic [31:0] inst, input logic wen,
                          input logic [4:0] rd, input logic [63:0] d, input logic brk);
    bit acc;
    int n;
    set_commit(pc, inst, wen, rd, d, brk);
    acc = 0;
    n = 0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = commit_ready;
      tick();
      n++;
    end
    commit_valid = 1'b0;
    if (!acc) begin
      checks++; errors++;
      $display("FAIL push_timeout: got no accept expected accept within 50 cycles");
    end
  endtask

  task automatic random_phase(input int cycles, input int brk_one_in);
    bit acc;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      acc = commit_valid & commit_ready;
      tick();
      if (!commit_valid || acc) begin
        if ($urandom_range(0, 3) != 0)
          set_commit({$urandom(), $urandom()}, $urandom(), 1'($urandom_range(0, 1)),
                     5'($urandom_range(0, 31)), {$urandom(), $urandom()},
                     brk_one_in > 0 && $urandom_range(1, brk_one_in) == 1);
        else
          commit_valid = 1'b0;
      end
      trace_ready = ($urandom_range(0, 2) != 0);
    end
    commit_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    commit_valid = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    commit_valid = 1'b0; commit_pc = '0; commit_inst = '0; commit_rd_wen = 1'b0;
    commit_rd = '0; commit_rd_data = '0; commit_is_break = 1'b0; trace_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // addi x10, x0, 5 drained immediately
    trace_ready = 1'b1;
    push_one(64'h8000_0000, 32'h0050_0513, 1'b1, 5'd10, 64'd5, 1'b0);
    repeat (3) tick();

    // fill with reader stalled, then pop+push while full
    trace_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      push_one(64'h8000_0004 + 64'(4*i), 32'h0000_0093, 1'b1, 5'(i + 1), 64'(100 + i), 1'b0);
    set_commit(64'h8000_0100, 32'h0000_0013, 1'b1, 5'd20, 64'hbad, 1'b0);
    trace_ready = 1'b1;
    tick();
    commit_valid = 1'b0;
    trace_ready  = 1'b0;
    tick();
    trace_ready = 1'b1;
    repeat (10) tick();

    // write to x0 must be ignored
    push_one(64'h8000_0200, 32'h0000_0013, 1'b1, 5'd0, 64'hdead, 1'b0);
    repeat (3) tick();

    random_phase(300, 0);
    trace_ready = 1'b1;
    repeat (12) tick();

    // ebreak with three entries queued behind a stalled reader
    push_one(64'h8000_0300, 32'h0000_0513, 1'b1, 5'd10, 64'd0, 1'b0);
    repeat (3) tick();
    trace_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      push_one(64'h8000_0304 + 64'(4*i), $urandom(), 1'b1, 5'(i + 11), {$urandom(), $urandom()}, 1'b0);
    push_one(64'h8000_0310, 32'h0010_0073, 1'b0, 5'd0, 64'd0, 1'b1);
    set_commit(64'h8000_0314, 32'h0000_0013, 1'b1, 5'd10, 64'h77, 1'b0);
    repeat (5) tick();
    trace_ready = 1'b1;
    begin
      int n = 0;
      while (!halt_valid && n < 100) begin
        tick();
        n++;
      end
      if (!halt_valid) begin
        checks++; errors++;
        $display("FAIL halt_timeout: got halt_valid=0 expected 1 within 100 cycles");
      end
    end
    repeat (5) tick();
    commit_valid = 1'b0;
    @(negedge clk);
    chk("halt_code_zero", halt_code, 64'd0);
    tick();

    // reset while draining with two entries queued
    do_reset();
    trace_ready = 1'b0;
    push_one(64'h8000_0400, 32'h0070_0293, 1'b1, 5'd5, 64'd7, 1'b0);
    push_one(64'h8000_0404, 32'h0010_0073, 1'b0, 5'd0, 64'd0, 1'b1);
    tick();
    do_reset();
    repeat (3) tick();

    random_phase(400, 40);
    trace_ready = 1'b1;
    repeat (20) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
